// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache between the CPU data port and memory port 2.
// Latency: read hit 0 cycles (cpu_ready in the request cycle), read miss 9 cycles, write 2 cycles.
// Backpressure: the CPU holds its request until the one-cycle cpu_ready pulse; the cache issues one memory request every other cycle.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   cpu_read/cpu_write           CPU request strobes (write wins if both are set)
//   cpu_addr/cpu_wdata           CPU word address and write data
//   cpu_rdata/cpu_ready          read data (zero unless a read completes) and completion pulse
//   mem_read/mem_write/mem_addr  memory request and address
//   mem_data                     bidirectional memory data, driven only while mem_write=1
//   hit_count/miss_count         read statistics, present only when DCACHE_STATS_EN is defined
module dcache_wt #(
    parameter int WORD_SIZE   = 16,
    parameter int INDEX_BITS  = 2,
    parameter int OFFSET_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    inout  wire  [WORD_SIZE-1:0] mem_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL_REQ  = 3'd1;
    localparam logic [2:0] S_FILL_WAIT = 3'd2;
    localparam logic [2:0] S_RESP      = 3'd3;
    localparam logic [2:0] S_WR_REQ    = 3'd4;
    localparam logic [2:0] S_WR_WAIT   = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [TAG_BITS-1:0]    tag_d  [LINES];
    logic [WORD_SIZE-1:0]   data_q [LINES][WORDS];
    logic [WORD_SIZE-1:0]   data_d [LINES][WORDS];

    // Fields of the live CPU address (used for hit lookup in IDLE).
    logic [TAG_BITS-1:0]    cpu_tag;
    logic [INDEX_BITS-1:0]  cpu_idx;
    logic [OFFSET_BITS-1:0] cpu_off;
    logic                   cpu_hit;

    // Fields of the latched request address (used once the request is accepted).
    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [OFFSET_BITS-1:0] req_off;
    logic                   req_hit;

    assign cpu_tag = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
    assign cpu_idx = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign cpu_off = cpu_addr[OFFSET_BITS-1:0];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    assign req_tag = addr_q[WORD_SIZE-1 -: TAG_BITS];
    assign req_idx = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_off = addr_q[OFFSET_BITS-1:0];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // The cache only owns the shared data bus during its write request cycle.
    assign mem_data = mem_write ? wdata_q : {WORD_SIZE{1'bz}};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tag_d     = tag_q;
        data_d    = data_q;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;

        case (state_q)
            S_IDLE: begin
                if (cpu_write) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_WR_REQ;
                end else if (cpu_read) begin
                    if (cpu_hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = data_q[cpu_idx][cpu_off];
                    end else begin
                        addr_d  = cpu_addr;
                        cnt_d   = '0;
                        state_d = S_FILL_REQ;
                    end
                end
            end
            S_FILL_REQ: begin
                // Counter replaces only the offset bits, so the fill never leaves the line.
                mem_read = 1'b1;
                mem_addr = {addr_q[WORD_SIZE-1:OFFSET_BITS], cnt_q};
                state_d  = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                data_d[req_idx][cnt_q] = mem_data;
                if (cnt_q == '1) begin
                    valid_d[req_idx] = 1'b1;
                    tag_d[req_idx]   = req_tag;
                    state_d          = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_FILL_REQ;
                end
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = data_q[req_idx][req_off];
                state_d   = S_IDLE;
            end
            S_WR_REQ: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                // Write-through: keep a cached copy coherent, never allocate on miss.
                if (req_hit) begin
                    data_d[req_idx][req_off] = wdata_q;
                end
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Datapath storage is not reset; valid bits alone decide whether contents are used.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

`ifdef DCACHE_STATS_EN
    logic        hit_inc;
    logic        miss_inc;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    // A miss is counted on the IDLE cycle that launches the fill.
    always_comb begin
        hit_inc      = (state_q == S_IDLE) && cpu_read && !cpu_write && cpu_hit;
        miss_inc     = (state_q == S_IDLE) && cpu_read && !cpu_write && !cpu_hit;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_inc && (hit_count_q != 16'hffff)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_inc && (miss_count_q != 16'hffff)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Testbench for dcache_wt: directed CPU requests against a one-cycle-latency memory model.
// Expected responses and memory transactions are queued by the stimulus and checked by monitors.
// Requests are driven just after the rising edge; all DUT outputs are sampled on the falling edge.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    wire  [15:0] mem_data;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    dcache_wt dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct packed {
        logic        is_read;
        logic [15:0] rdata;
        logic [7:0]  lat;
    } resp_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dat;
    } mem_tx_t;

    resp_t   resp_q[$];
    mem_tx_t mtx_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cyc = 0;
    logic prev_mreq = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model: one-cycle read data, write commits one cycle later
    logic [15:0] mem [256];
    logic        drv_en = 1'b0;
    logic [15:0] drv_dat = '0;
    logic        wr_pend = 1'b0;
    logic [15:0] wr_a = '0;
    logic [15:0] wr_d = '0;
    logic        n_rd = 1'b0;
    logic        n_wr = 1'b0;
    logic [15:0] n_addr = '0;
    logic [15:0] n_data = '0;

    assign mem_data = drv_en ? drv_dat : 16'hzzzz;

    always @(negedge clk) begin
        n_rd   = mem_read;
        n_wr   = mem_write;
        n_addr = mem_addr;
        n_data = mem_data;
    end

    always @(posedge clk) begin
        if (wr_pend) mem[wr_a[7:0]] <= wr_d;
        drv_en  <= n_rd;
        drv_dat <= mem[n_addr[7:0]];
        wr_pend <= n_wr;
        wr_a    <= n_addr;
        wr_d    <= n_data;
    end

    // ---------------- monitors
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_read || mem_write) begin
                mem_tx_t e;
                check("mem_gap", 16'(prev_mreq), 16'd0);
                if (mtx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_unexpected: got rd=%0d wr=%0d addr %h want no request", mem_read, mem_write, mem_addr);
                end else begin
                    e = mtx_q.pop_front();
                    check("mem_kind", 16'(mem_write), 16'(e.wr));
                    check("mem_addr", mem_addr, e.addr);
                    if (e.wr) check("mem_wdata", mem_data, e.dat);
                end
            end
            prev_mreq = mem_read || mem_write;
            if (cpu_ready) begin
                resp_t r;
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ready_unexpected: got cpu_ready=1 want 0");
                end else begin
                    r = resp_q.pop_front();
                    if (r.is_read) check("cpu_rdata", cpu_rdata, r.rdata);
                    check("latency", 16'(cyc - req_cyc), 16'(r.lat));
                end
            end
        end else begin
            prev_mreq = 1'b0;
        end
    end

    // ---------------- stimulus helpers
    task automatic exp_fill(input logic [15:0] base);
        mem_tx_t t;
        for (int i = 0; i < 4; i++) begin
            t.wr   = 1'b0;
            t.addr = base + 16'(i);
            t.dat  = '0;
            mtx_q.push_back(t);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        mem_tx_t t;
        t.wr   = 1'b1;
        t.addr = a;
        t.dat  = d;
        mtx_q.push_back(t);
    endtask

    task automatic cpu_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] exp_rd, input int lat);
        resp_t r;
        logic  got;
        r.is_read = !wr;
        r.rdata   = exp_rd;
        r.lat     = 8'(lat);
        resp_q.push_back(r);
        @(posedge clk);
        #1;
        cpu_read  = !wr;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        req_cyc   = cyc;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no cpu_ready for addr %h want ready within 40 cycles", a);
            if (resp_q.size() > 0) resp_q.delete(0);
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h23] = 16'h6000;
        mem[8'h24] = 16'hf01c;
        mem[8'h25] = 16'h2525;
        mem[8'h34] = 16'h3434;
        mem[8'h64] = 16'h0a64;

        reset_n   = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready", 16'(cpu_ready), 16'd0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0000);
        check("rst_mem_read", 16'(mem_read), 16'd0);
        check("rst_mem_write", 16'(mem_write), 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // cold miss, then hit in the same line
        exp_fill(16'h0020);
        cpu_req(1'b0, 16'h0023, 16'h0000, 16'h6000, 9);
        cpu_req(1'b0, 16'h0020, 16'h0000, 16'h0000, 0);
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("hit_count", hit_count, 16'd1);
        check("miss_count", miss_count, 16'd1);
`endif

        // write hit updates cache and memory
        exp_wr(16'h0021, 16'hbeef);
        cpu_req(1'b1, 16'h0021, 16'hbeef, 16'h0000, 2);
        cpu_req(1'b0, 16'h0021, 16'h0000, 16'hbeef, 0);

        // write miss: memory only, then read fills and returns written value
        exp_wr(16'h0050, 16'h1234);
        cpu_req(1'b1, 16'h0050, 16'h1234, 16'h0000, 2);
        exp_fill(16'h0050);
        cpu_req(1'b0, 16'h0050, 16'h0000, 16'h1234, 9);

        // line 0 was replaced; memory holds the earlier write-through value
        exp_fill(16'h0020);
        cpu_req(1'b0, 16'h0021, 16'h0000, 16'hbeef, 9);

        // conflict misses on index 1
        exp_fill(16'h0024);
        cpu_req(1'b0, 16'h0024, 16'h0000, 16'hf01c, 9);
        exp_fill(16'h0064);
        cpu_req(1'b0, 16'h0064, 16'h0000, 16'h0a64, 9);
        exp_fill(16'h0024);
        cpu_req(1'b0, 16'h0024, 16'h0000, 16'hf01c, 9);
        cpu_req(1'b0, 16'h0025, 16'h0000, 16'h2525, 0);

        // reset during FILL_WAIT
        begin
            mem_tx_t t;
            t.wr   = 1'b0;
            t.addr = 16'h0034;
            t.dat  = '0;
            mtx_q.push_back(t);
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b1;
        cpu_addr = 16'h0034;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_mem_read", 16'(mem_read), 16'd0);
        check("midrst_mem_write", 16'(mem_write), 16'd0);
        check("midrst_mem_addr", mem_addr, 16'h0000);
        check("midrst_cpu_ready", 16'(cpu_ready), 16'd0);
        check("midrst_cpu_rdata", cpu_rdata, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // valid bits cleared: previously cached line misses again
        exp_fill(16'h0024);
        cpu_req(1'b0, 16'h0024, 16'h0000, 16'hf01c, 9);
        exp_fill(16'h0034);
        cpu_req(1'b0, 16'h0034, 16'h0000, 16'h3434, 9);

        repeat (4) @(negedge clk);
        check("resp_left", 16'(resp_q.size()), 16'd0);
        check("memtx_left", 16'(mtx_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the data port (port 2) of the shared memory.
- Hides memory latency on read hits.
- Line fills issue word reads to memory one at a time.
- All writes are forwarded to memory; on a write hit the cached copy is also updated.

Parameters:
- WORD_SIZE, 16, data and address width.
- INDEX_BITS, 2, log2 of line count (4 lines).
- OFFSET_BITS, 2, log2 of words per line (4 words).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- cpu_read  in  1  read request; held until cpu_ready
- cpu_write  in  1  write request; held until cpu_ready
- cpu_addr  in  16  word address
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data; valid when cpu_ready and cpu_read
- cpu_ready  out  1  request-complete pulse, 1 cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_addr  out  16  memory address
- mem_data  inout  16  driven by cache only while mem_write=1, else high-Z

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Address split: tag = cpu_addr[15:4], index = [3:2], offset = [1:0]. Per line: valid bit, 12-bit tag, 4 words.
- Memory timing, per single request:
  - A request driven in cycle t has read data valid on mem_data during t+1; the cache captures it at the end of t+1.
  - A write commits at the end of t+1.
  - The cache never issues back-to-back requests: every request cycle is followed by a wait cycle with mem_read = mem_write = 0.
- States: IDLE, FILL_REQ, FILL_WAIT, RESP, WR_REQ, WR_WAIT.
- IDLE:
  - Read hit: cpu_ready=1 combinationally in the same cycle, cpu_rdata = cached word, stay in IDLE.
  - Read miss: latch line base address (cpu_addr & ~3), word counter = 0, go to FILL_REQ.
  - Write: latch address and data, go to WR_REQ.
  - cpu_read and cpu_write together is illegal; write takes priority.
- FILL_REQ: mem_read=1, mem_addr = base + counter, go to FILL_WAIT.
- FILL_WAIT: capture mem_data into line word[counter]. If counter==3: set valid, write tag, go to RESP. Else increment counter and return to FILL_REQ.
- RESP: cpu_ready=1, cpu_rdata = requested word from the newly filled line, go to IDLE. Read-miss latency is 9 cycles after the request cycle.
- WR_REQ: mem_write=1, mem_addr and mem_data = latched values. On hit (valid and tag match), update the cached word this cycle. Go to WR_WAIT.
- WR_WAIT: cpu_ready=1, go to IDLE. Write latency is 2 cycles. A write miss leaves cache contents unchanged.
- A fill replaces the line unconditionally; there are no dirty bits.
- cpu_ready is 0 in every state/cycle not listed above.
- Request changes mid-miss are ignored; the cache works from the latched address.
- Reset (including mid-fill or mid-write):
  - All valid bits cleared, state IDLE, counter 0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_data high-Z.
  - cpu_ready=0, cpu_rdata=0.
  - Line data arrays are not cleared.
- Address wrap: base + counter never crosses a line boundary, since counter only touches the 2 offset bits.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each counter increments once per completed read (hit in IDLE, miss on entry to FILL_REQ).
  - Counters saturate at 16'hffff and reset to 0.
  - Writes are not counted.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- After reset, cpu_read addr 0x0023 (memory holds 0x6000):
  - mem_read pulses at addresses 0x20, 0x21, 0x22, 0x23 on alternate cycles.
  - cpu_ready 9 cycles after the request with cpu_rdata=0x6000.
- Then cpu_read 0x0020: cpu_ready in the same cycle, cpu_rdata=0x0000, no mem_read.
- cpu_write 0x0021 data 0xbeef (line cached):
  - mem_write=1, addr 0x21, data 0xbeef for 1 cycle; cpu_ready 2 cycles after the request.
  - Subsequent read 0x0021 hits with 0xbeef.
- cpu_write 0x0050 data 0x1234 (miss): memory written, no fill. A following read 0x0050 misses, fills 0x50–0x53, returns 0x1234.
- Conflict: read 0x0024 (fills index 1, returns 0xf01c), then read 0x0064 (same index, tag differs) misses and refills. Re-read 0x0024 misses again.
- Assert reset_n=0 during FILL_WAIT of a miss: mem_read=0 next cycle, state IDLE, and re-reading the same address misses.
- With DCACHE_STATS_EN defined: run the first two scenarios, expect hit_count=1, miss_count=1.
